// File: rtl/centroid_marker.sv
// rtl/centroid_marker.sv - crosshair overlay at a per-frame latched centroid
// Two-stage pixel pipeline: stage 1 tags each pixel with its column/row, stage 2 paints the marker.
module centroid_marker #(
   parameter int          IMG_W    = 64,
   parameter int          IMG_H    = 64,
   parameter int          ARM      = 4,
   parameter logic [23:0] MARK_RGB = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [23:0] pixel_in,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        enable,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [23:0] pixel_out
);

   localparam logic [11:0] W_L     = 12'(IMG_W);
   localparam logic [11:0] H_L     = 12'(IMG_H);
   localparam logic [11:0] ARM_L   = 12'(ARM);
   localparam logic [10:0] CNT_MAX = 11'h7FF;

   logic        de_prev_q, vs_prev_q;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic [10:0] mark_x_q, mark_x_d;
   logic [10:0] mark_y_q, mark_y_d;
   logic        mark_ok_q, mark_ok_d;

   logic        s1_de_q, s1_hs_q, s1_vs_q, s1_en_q;
   logic [23:0] s1_pix_q;
   logic [10:0] s1_h_q, s1_v_q;

   logic        de_out_q, hsync_out_q, vsync_out_q;
   logic [23:0] pixel_out_q;

   logic        vs_rise, de_fall, hit;
   logic [11:0] dx, dy;
   logic [23:0] pix_d;

   always_comb begin
      vs_rise   = vsync & ~vs_prev_q;
      de_fall   = de_prev_q & ~de;

      h_cnt_d = h_cnt_q;
      if (de) begin
         if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 11'd1;
      end else if (de_fall) begin
         h_cnt_d = 11'd0;
      end

      // A vsync rise on the same clk as the last line's de fall must start the frame at row 0.
      v_cnt_d = v_cnt_q;
      if (vs_rise) begin
         v_cnt_d = 11'd0;
      end else if (de_fall && v_cnt_q != CNT_MAX) begin
         v_cnt_d = v_cnt_q + 11'd1;
      end

      mark_x_d  = mark_x_q;
      mark_y_d  = mark_y_q;
      mark_ok_d = mark_ok_q;
      if (vs_rise) begin
         mark_x_d  = x;
         mark_y_d  = y;
         mark_ok_d = ({1'b0, x} < W_L) && ({1'b0, y} < H_L);
      end

      if (s1_h_q >= mark_x_q) dx = {1'b0, s1_h_q} - {1'b0, mark_x_q};
      else                    dx = {1'b0, mark_x_q} - {1'b0, s1_h_q};
      if (s1_v_q >= mark_y_q) dy = {1'b0, s1_v_q} - {1'b0, mark_y_q};
      else                    dy = {1'b0, mark_y_q} - {1'b0, s1_v_q};

      hit = s1_de_q & s1_en_q & mark_ok_q &
            (((s1_v_q == mark_y_q) && (dx <= ARM_L)) ||
             ((s1_h_q == mark_x_q) && (dy <= ARM_L)));
      pix_d = hit ? MARK_RGB : s1_pix_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         de_prev_q   <= 1'b0;
         vs_prev_q   <= 1'b0;
         h_cnt_q     <= 11'd0;
         v_cnt_q     <= 11'd0;
         mark_x_q    <= 11'd0;
         mark_y_q    <= 11'd0;
         mark_ok_q   <= 1'b0;
         s1_de_q     <= 1'b0;
         s1_hs_q     <= 1'b0;
         s1_vs_q     <= 1'b0;
         s1_en_q     <= 1'b0;
         s1_pix_q    <= 24'd0;
         s1_h_q      <= 11'd0;
         s1_v_q      <= 11'd0;
         de_out_q    <= 1'b0;
         hsync_out_q <= 1'b0;
         vsync_out_q <= 1'b0;
         pixel_out_q <= 24'd0;
      end else begin
         de_prev_q   <= de;
         vs_prev_q   <= vsync;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         mark_x_q    <= mark_x_d;
         mark_y_q    <= mark_y_d;
         mark_ok_q   <= mark_ok_d;
         s1_de_q     <= de;
         s1_hs_q     <= hsync;
         s1_vs_q     <= vsync;
         s1_en_q     <= enable;
         s1_pix_q    <= pixel_in;
         s1_h_q      <= h_cnt_q;
         s1_v_q      <= v_cnt_q;
         de_out_q    <= s1_de_q;
         hsync_out_q <= s1_hs_q;
         vsync_out_q <= s1_vs_q;
         pixel_out_q <= pix_d;
      end
   end

   assign de_out    = de_out_q;
   assign hsync_out = hsync_out_q;
   assign vsync_out = vsync_out_q;
   assign pixel_out = pixel_out_q;

endmodule

// File: tb/tb_centroid_marker.sv
// tb/tb_centroid_marker.sv - randomized frame-level bench for centroid_marker
// The reference model knows each pixel's row/column from the frame loops and applies the crosshair rule directly.
module tb_centroid_marker;

   localparam int          W    = 64;
   localparam int          H    = 64;
   localparam int          ARM  = 4;
   localparam logic [23:0] MARK = 24'hFF0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        de = 1'b0, hsync = 1'b0, vsync = 1'b0, enable = 1'b0;
   logic [23:0] pixel_in = 24'd0;
   logic [10:0] x = 11'd0, y = 11'd0;
   logic        de_out, hsync_out, vsync_out;
   logic [23:0] pixel_out;

   centroid_marker #(.IMG_W(W), .IMG_H(H), .ARM(ARM), .MARK_RGB(MARK)) dut (
      .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
      .pixel_in(pixel_in), .x(x), .y(y), .enable(enable),
      .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel_out(pixel_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // expected {de,hsync,vsync,pixel} of inputs still inside the 2-clk pipeline
   logic [26:0] exp_q[$];
   int          m_x, m_y;
   bit          m_ok;
   logic [10:0] cur_x = 11'd0, cur_y = 11'd0;

   int          f_bad_pix, f_bad_ctl, f_marked, cyc_n = 0, fb_cyc;
   logic [26:0] fb_obs, fb_exp;

   function automatic bit exp_hit(int row, int col, bit en);
      int dx, dy;
      dx = (col > m_x) ? col - m_x : m_x - col;
      dy = (row > m_y) ? row - m_y : m_y - row;
      return en && m_ok && ((row == m_y && dx <= ARM) || (col == m_x && dy <= ARM));
   endfunction

   function automatic logic [23:0] rand_pix();
      logic [23:0] p;
      p = 24'($urandom);
      if (p == MARK) p = p ^ 24'h1;
      return p;
   endfunction

   task automatic clear_tally();
      f_bad_pix = 0; f_bad_ctl = 0; f_marked = 0; fb_cyc = -1;
      fb_obs = '0; fb_exp = '0;
   endtask

   task automatic cyc(input logic d, input logic h, input logic v, input logic [23:0] p,
                      input logic en, input bit hit, input bit rst_act);
      logic [26:0] obs, e;
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() == 2) begin
         obs = {de_out, hsync_out, vsync_out, pixel_out};
         e   = exp_q.pop_front();
         if (obs[26:24] !== e[26:24]) f_bad_ctl++;
         if (obs !== e && fb_cyc < 0) begin fb_cyc = cyc_n; fb_obs = obs; fb_exp = e; end
         if (obs[23:0] !== e[23:0]) f_bad_pix++;
         if (obs[26] === 1'b1 && obs[23:0] === MARK) f_marked++;
      end
      de = d; hsync = h; vsync = v; pixel_in = p; enable = en;
      x = cur_x; y = cur_y; rst_n = ~rst_act;
      if (rst_act) begin
         foreach (exp_q[i]) exp_q[i] = '0;
         exp_q.push_back('0);
      end else begin
         exp_q.push_back({d, h, v, hit ? MARK : p});
      end
   endtask

   // en_mode: 0 enable held 1, 1 enable drops at (er,ec), 2 random toggling
   task automatic frame(input int fx, input int fy, input int en_mode, input int er, input int ec,
                        input int rr, input int rc, input bit tight);
      int rst_left;
      bit en;
      rst_left = 0;
      en = 1'b1;
      clear_tally();
      cur_x = 11'(fx);
      cur_y = 11'(fy);
      m_x = fx; m_y = fy; m_ok = (fx < W) && (fy < H);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, rand_pix(), en, 1'b0, 1'b0);
      cur_x = 11'($urandom);
      cur_y = 11'($urandom);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, rand_pix(), en, 1'b0, 1'b0);
      for (int row = 0; row < H; row++) begin
         for (int col = 0; col < W; col++) begin
            if (en_mode == 1) en = !(row > er || (row == er && col >= ec));
            if (en_mode == 2 && $urandom_range(0, 15) == 0) en = ~en;
            if (row == rr && col == rc) begin rst_left = 3; m_ok = 1'b0; end
            cyc(1'b1, 1'b0, 1'b0, rand_pix(), en, exp_hit(row, col, en), rst_left > 0);
            if (rst_left > 0) rst_left--;
         end
         if (!(tight && row == H - 1))
            for (int i = 0; i < 4; i++) cyc(1'b0, i inside {[1:2]}, 1'b0, rand_pix(), en, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      clear_tally();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, rand_pix(), 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({de_out, hsync_out, vsync_out} !== 3'b000) begin
         n_bad++; $display("FAIL reset_ctl: observed %b required 000", {de_out, hsync_out, vsync_out});
      end
      n_cmp++;
      if (pixel_out !== 24'd0) begin
         n_bad++; $display("FAIL reset_pix: observed %h required 000000", pixel_out);
      end
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, rand_pix(), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (f_bad_pix + f_bad_ctl !== 0) begin
         n_bad++; $display("FAIL reset_stream: observed %0d bad required 0 (obs %h exp %h)", f_bad_pix + f_bad_ctl, fb_obs, fb_exp);
      end
   endtask

   task automatic test_basic();
      for (int f = 0; f < 2; f++) begin
         frame(20, 30, 0, 0, 0, -1, -1, 1'b0);
         n_cmp++;
         if (f_bad_pix !== 0) begin
            n_bad++; $display("FAIL basic_pix f%0d: observed %0d bad required 0 (cyc %0d obs %h exp %h)", f, f_bad_pix, fb_cyc, fb_obs, fb_exp);
         end
         n_cmp++;
         if (f_bad_ctl !== 0) begin
            n_bad++; $display("FAIL basic_ctl f%0d: observed %0d bad required 0", f, f_bad_ctl);
         end
         n_cmp++;
         if (f_marked !== 17) begin
            n_bad++; $display("FAIL basic_marked f%0d: observed %0d required 17", f, f_marked);
         end
      end
   endtask

   task automatic test_edges();
      frame(1, 62, 0, 0, 0, -1, -1, 1'b0);
      n_cmp++;
      if (f_bad_pix !== 0) begin
         n_bad++; $display("FAIL edge_pix: observed %0d bad required 0 (cyc %0d obs %h exp %h)", f_bad_pix, fb_cyc, fb_obs, fb_exp);
      end
      n_cmp++;
      if (f_marked !== 11) begin
         n_bad++; $display("FAIL edge_marked: observed %0d required 11", f_marked);
      end
   endtask

   task automatic test_out_of_range();
      frame(64, 10, 0, 0, 0, -1, -1, 1'b0);
      n_cmp++;
      if (f_marked !== 0 || f_bad_pix !== 0) begin
         n_bad++; $display("FAIL oor_marked: observed %0d marked %0d bad required 0 0", f_marked, f_bad_pix);
      end
      frame(10, 10, 0, 0, 0, -1, -1, 1'b0);
      n_cmp++;
      if (f_marked !== 17) begin
         n_bad++; $display("FAIL oor_recover: observed %0d required 17", f_marked);
      end
      n_cmp++;
      if (f_bad_pix !== 0) begin
         n_bad++; $display("FAIL oor_recover_pix: observed %0d bad required 0 (obs %h exp %h)", f_bad_pix, fb_obs, fb_exp);
      end
   endtask

   task automatic test_enable_toggle();
      frame(20, 30, 1, 30, 18, -1, -1, 1'b0);
      n_cmp++;
      if (f_marked !== 6) begin
         n_bad++; $display("FAIL enable_marked: observed %0d required 6", f_marked);
      end
      n_cmp++;
      if (f_bad_pix !== 0 || f_bad_ctl !== 0) begin
         n_bad++; $display("FAIL enable_stream: observed %0d/%0d bad required 0/0 (obs %h exp %h)", f_bad_pix, f_bad_ctl, fb_obs, fb_exp);
      end
   endtask

   task automatic test_reset_mid();
      frame(20, 30, 0, 0, 0, 10, 5, 1'b0);
      n_cmp++;
      if (f_marked !== 0) begin
         n_bad++; $display("FAIL midreset_marked: observed %0d required 0", f_marked);
      end
      n_cmp++;
      if (f_bad_pix !== 0 || f_bad_ctl !== 0) begin
         n_bad++; $display("FAIL midreset_stream: observed %0d/%0d bad required 0/0 (cyc %0d obs %h exp %h)", f_bad_pix, f_bad_ctl, fb_cyc, fb_obs, fb_exp);
      end
      frame(20, 30, 0, 0, 0, -1, -1, 1'b0);
      n_cmp++;
      if (f_marked !== 17 || f_bad_pix !== 0) begin
         n_bad++; $display("FAIL midreset_recover: observed %0d marked %0d bad required 17 0", f_marked, f_bad_pix);
      end
   endtask

   task automatic test_back_to_back();
      frame(20, 30, 0, 0, 0, -1, -1, 1'b1);
      frame(33, 50, 0, 0, 0, -1, -1, 1'b0);
      n_cmp++;
      if (f_marked !== 17) begin
         n_bad++; $display("FAIL b2b_marked: observed %0d required 17", f_marked);
      end
      n_cmp++;
      if (f_bad_pix !== 0 || f_bad_ctl !== 0) begin
         n_bad++; $display("FAIL b2b_stream: observed %0d/%0d bad required 0/0 (cyc %0d obs %h exp %h)", f_bad_pix, f_bad_ctl, fb_cyc, fb_obs, fb_exp);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 2; f++) begin
         frame($urandom_range(0, 70), $urandom_range(0, 70), 2, 0, 0, -1, -1, 1'b0);
         n_cmp++;
         if (f_bad_pix !== 0) begin
            n_bad++; $display("FAIL random_pix f%0d: observed %0d bad required 0 (cyc %0d obs %h exp %h)", f, f_bad_pix, fb_cyc, fb_obs, fb_exp);
         end
         n_cmp++;
         if (f_bad_ctl !== 0) begin
            n_bad++; $display("FAIL random_ctl f%0d: observed %0d bad required 0", f, f_bad_ctl);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_out_of_range();
      test_enable_toggle();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/centroid_marker.md
CENTROID_MARKER -- requirements
Module: centroid_marker

Interface
REQ-001 Parameter IMG_W, default 64: active pixels per line.
REQ-002 Parameter IMG_H, default 64: active lines per frame.
REQ-003 Parameter ARM, default 4: crosshair half-length in pixels (0..63).
REQ-004 Parameter MARK_RGB, default 24'hFF0000: overlay colour {R,G,B}.
REQ-005 clk  in  1  pixel clock; the block's only clock.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 de  in  1  data enable of incoming video.
REQ-008 hsync  in  1  horizontal sync of incoming video.
REQ-009 vsync  in  1  vertical sync of incoming video, active high.
REQ-010 pixel_in  in  24  incoming pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 x  in  11  centroid column from the centroid stage; sampled only as in REQ-016.
REQ-012 y  in  11  centroid row from the centroid stage; sampled only as in REQ-016.
REQ-013 enable  in  1  1 = draw marker, 0 = pass video unchanged.
REQ-014 de_out, hsync_out, vsync_out  out  1 each  de, hsync, vsync delayed exactly 2 clk.
REQ-015 pixel_out  out  24  pixel_in delayed 2 clk, or MARK_RGB on marker pixels.

Function
REQ-016 Centroid latch: on the clk where vsync goes 0->1, mark_x<=x and mark_y<=y; the frame after that edge uses the latched pair (one-frame marker lag, by design).
REQ-017 mark_ok <= (x<IMG_W)&&(y<IMG_H) on the same edge; mark_ok=0 suppresses the marker for the whole frame.
REQ-018 Column counter h_cnt (11 bit): increments on each clk with de=1, clears to 0 on de 1->0; saturates at 2047, no wrap.
REQ-019 Row counter v_cnt (11 bit): increments on each de 1->0; clears to 0 on vsync 0->1; saturates at 2047.
REQ-020 Simultaneous de 1->0 and vsync 0->1: the clear wins, v_cnt=0.
REQ-021 Stage 1 registers the video and the h_cnt/v_cnt of that pixel; stage 2 computes the hit and drives the outputs; total latency is 2 clk for all outputs.
REQ-022 Hit = de & enable & mark_ok & ((v_cnt==mark_y & |h_cnt-mark_x|<=ARM) | (h_cnt==mark_x & |v_cnt-mark_y|<=ARM)).
REQ-023 Distances use 12-bit unsigned absolute differences; there is no underflow or wrap, and arms are clipped at the image edges (e.g. mark_x=1, ARM=4 draws columns 0..5 only).
REQ-024 pixel_out = MARK_RGB when hit, else the delayed pixel_in; when de=0 the delayed pixel_in is passed unchanged.
REQ-025 A change to enable takes effect on the pixel entering stage 1 on that clk; there is no frame alignment.
REQ-026 The block adds no back-pressure; it accepts one pixel every clk.

Reset
REQ-027 While rst_n=0 at a clk edge, all pipeline registers clear: de_out=0, hsync_out=0, vsync_out=0, pixel_out=0.
REQ-028 Reset also clears h_cnt=0, v_cnt=0, mark_x=0, mark_y=0 and mark_ok=0, so no marker is drawn until the first vsync rise after reset.
REQ-029 Reset mid-frame discards the counters; the partial frame after release passes unmarked, and drawing resumes after the next vsync 0->1.

Verification
REQ-030 64x64 frames, x=20, y=30, enable=1, ARM=4 -> in the second frame, row 30 columns 16..24 and column 20 rows 26..34 are FF0000; all other pixels equal the input delayed 2 clk.
REQ-031 x=1, y=62 -> row 62 columns 0..5 and column 1 rows 58..63 are marked; no marker on column 2047, row 0, or any wrapped position.
REQ-032 x=64 (out of range) latched at vsync -> the following frame is identical to the input; the next frame with x=10 is marked normally.
REQ-033 enable toggled 1->0 at row 30 column 18 -> columns 16..17 of row 30 are marked, columns 18..24 are not; de/hsync/vsync_out always equal the inputs delayed 2 clk.
REQ-034 rst_n=0 for 3 clk mid-frame -> outputs are 0 during reset; after release the remainder of the frame is unmarked, and the marker reappears one full frame after the next vsync rise.
REQ-035 Last de 1->0 of a frame coincident with vsync 0->1 -> v_cnt=0 on the next clk, and the next frame's marker rows are correctly positioned.
